// File: rtl/pulse_period_meter.sv
// Measures the spacing, in clk cycles, between rising edges of i_pulse.
// A timeout strobe fires when no edge arrives within MAX_PERIOD cycles.
module pulse_period_meter #(
  parameter int  MAX_PERIOD = 100_000_000,
  localparam int CNT_W      = $clog2(MAX_PERIOD + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_enable,
  input  logic             i_pulse,
  output logic [CNT_W-1:0] o_period,
  output logic             o_valid,
  output logic             o_timeout,
  output logic             o_busy
);

  localparam logic [0:0]       ST_IDLE    = 1'b0;
  localparam logic [0:0]       ST_MEASURE = 1'b1;
  localparam logic [CNT_W-1:0] MAX_CNT    = CNT_W'(MAX_PERIOD);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic             s1_q;
  logic             s2_q;
  logic             s3_q;
  logic             pulse_edge;
  logic [0:0]       state_q;
  logic [0:0]       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] period_d;
  logic             valid_q;
  logic             valid_d;
  logic             timeout_q;
  logic             timeout_d;

  // These flops ignore i_enable so a level held high across an enable gap
  // is not mistaken for a fresh rising edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= i_pulse;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign pulse_edge = s2_q & ~s3_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    valid_d   = 1'b0;
    timeout_d = 1'b0;
    if (!i_enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          if (pulse_edge) begin
            cnt_d   = CNT_ONE;
            state_d = ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          // An edge on the terminal count still counts as a measurement.
          if (pulse_edge) begin
            period_d = cnt_q;
            valid_d  = 1'b1;
            cnt_d    = CNT_ONE;
          end else if (cnt_q == MAX_CNT) begin
            timeout_d = 1'b1;
            cnt_d     = '0;
            state_d   = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_period  = period_q;
  assign o_valid   = valid_q;
  assign o_timeout = timeout_q;
  assign o_busy    = (state_q == ST_MEASURE);

endmodule

// File: tb/tb_pulse_period_meter.sv
// Self-checking bench for pulse_period_meter, using a timestamp-based
// reference model of rising-edge spacing and timeouts.
module tb_pulse_period_meter;

  localparam int MAXP  = 50;
  localparam int CNT_W = $clog2(MAXP + 1);

  logic             clk;
  logic             reset;
  logic             i_enable;
  logic             i_pulse;
  logic [CNT_W-1:0] o_period;
  logic             o_valid;
  logic             o_timeout;
  logic             o_busy;

  int checks = 0;
  int errors = 0;

  pulse_period_meter #(.MAX_PERIOD(MAXP)) dut (
    .clk      (clk),
    .reset    (reset),
    .i_enable (i_enable),
    .i_pulse  (i_pulse),
    .o_period (o_period),
    .o_valid  (o_valid),
    .o_timeout(o_timeout),
    .o_busy   (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: rises are timestamped by the posedge that first samples
  // i_pulse high; each one is acted on two posedges later.
  int               n         = 0;
  int               rise_a    = -100;
  int               rise_b    = -100;
  int               last_rise = 0;
  logic             prev_samp = 1'b0;
  logic             armed     = 1'b0;
  logic [CNT_W-1:0] m_period  = '0;
  logic             m_valid   = 1'b0;
  logic             m_timeout = 1'b0;
  logic             m_busy;
  logic             m_edge;

  assign m_edge = (rise_a == n - 2) || (rise_b == n - 2);
  assign m_busy = armed;

  always @(posedge clk) begin
    n <= n + 1;
    if (reset) begin
      prev_samp <= 1'b0;
      rise_a    <= -100;
      rise_b    <= -100;
      armed     <= 1'b0;
      last_rise <= 0;
      m_period  <= '0;
      m_valid   <= 1'b0;
      m_timeout <= 1'b0;
    end else begin
      prev_samp <= i_pulse;
      if (i_pulse && !prev_samp) begin
        rise_b <= rise_a;
        rise_a <= n;
      end
      m_valid   <= 1'b0;
      m_timeout <= 1'b0;
      if (!i_enable) begin
        armed <= 1'b0;
      end else if (m_edge) begin
        if (armed) begin
          m_period <= CNT_W'(n - 2 - last_rise);
          m_valid  <= 1'b1;
        end
        armed     <= 1'b1;
        last_rise <= n - 2;
      end else if (armed && (n - last_rise - 2 == MAXP)) begin
        m_timeout <= 1'b1;
        armed     <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && o_valid)   $display("measure: period=%0d at %0t", o_period, $time);
    if (!reset && o_timeout) $display("timeout at %0t (period holds %0d)", $time, o_period);
  end

  task automatic test_reset;
    reset    = 1'b1;
    i_enable = 1'b0;
    i_pulse  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (o_period !== '0 || o_valid !== 1'b0 || o_timeout !== 1'b0 || o_busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_state period=%0d valid=%b timeout=%b busy=%b required all zero",
                 o_period, o_valid, o_timeout, o_busy);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_divider_ticks;
    int nvalid;
    nvalid   = 0;
    i_enable = 1'b1;
    for (int k = 0; k < 70; k++) begin
      @(negedge clk);
      checks++;
      if (o_valid !== m_valid || o_timeout !== m_timeout || o_busy !== m_busy || o_period !== m_period) begin
        errors++;
        $display("FAIL ticks10_model t=%0t got p=%0d v=%b to=%b b=%b required p=%0d v=%b to=%b b=%b",
                 $time, o_period, o_valid, o_timeout, o_busy, m_period, m_valid, m_timeout, m_busy);
      end
      if (o_valid) begin
        nvalid++;
        checks++;
        if (o_period !== CNT_W'(10)) begin
          errors++;
          $display("FAIL ticks10_period got %0d required 10", o_period);
        end
      end
      if (k == 5) begin
        checks++;
        if (o_busy !== 1'b1 || nvalid != 0) begin
          errors++;
          $display("FAIL ticks10_first got busy=%b valids=%0d required busy=1 valids=0", o_busy, nvalid);
        end
      end
      i_pulse = (k % 10 == 0);
    end
    checks++;
    if (nvalid != 6) begin
      errors++;
      $display("FAIL ticks10_count got %0d valids required 6", nvalid);
    end
  endtask

  task automatic test_interval_seq;
    int got[$];
    int exp_v[3] = '{10, 25, 2};
    int nto;
    nto = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      checks++;
      if (o_valid !== m_valid || o_timeout !== m_timeout || o_busy !== m_busy || o_period !== m_period) begin
        errors++;
        $display("FAIL seq_model t=%0t got p=%0d v=%b to=%b b=%b required p=%0d v=%b to=%b b=%b",
                 $time, o_period, o_valid, o_timeout, o_busy, m_period, m_valid, m_timeout, m_busy);
      end
      if (k >= 4 && o_valid) got.push_back(int'(o_period));
      if (k >= 4 && o_timeout) nto++;
      i_enable = (k >= 2);
      i_pulse  = (k == 4) || (k == 14) || (k == 39) || (k == 41);
    end
    checks++;
    if (got.size() != 3 || nto != 0) begin
      errors++;
      $display("FAIL seq_count got %0d valids %0d timeouts required 3 valids 0 timeouts", got.size(), nto);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got[i] != exp_v[i]) begin
          errors++;
          $display("FAIL seq_value[%0d] got %0d required %0d", i, got[i], exp_v[i]);
        end
      end
    end
  endtask

  task automatic test_timeout;
    int got[$];
    int exp_v[3] = '{50, 50, 7};
    int nto;
    nto = 0;
    for (int k = 0; k < 175; k++) begin
      @(negedge clk);
      checks++;
      if (o_valid !== m_valid || o_timeout !== m_timeout || o_busy !== m_busy || o_period !== m_period) begin
        errors++;
        $display("FAIL timeout_model t=%0t got p=%0d v=%b to=%b b=%b required p=%0d v=%b to=%b b=%b",
                 $time, o_period, o_valid, o_timeout, o_busy, m_period, m_valid, m_timeout, m_busy);
      end
      if (k >= 4 && o_valid) got.push_back(int'(o_period));
      if (k >= 4 && o_timeout) begin
        nto++;
        checks++;
        if (o_busy !== 1'b0 || o_period !== CNT_W'(50) || o_valid !== 1'b0) begin
          errors++;
          $display("FAIL timeout_strobe got busy=%b period=%0d valid=%b required busy=0 period=50 valid=0",
                   o_busy, o_period, o_valid);
        end
      end
      i_enable = (k >= 2);
      i_pulse  = (k == 4) || (k == 54) || (k == 104) || (k == 155) || (k == 162);
    end
    checks++;
    if (got.size() != 3 || nto != 1) begin
      errors++;
      $display("FAIL timeout_count got %0d valids %0d timeouts required 3 valids 1 timeout", got.size(), nto);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got[i] != exp_v[i]) begin
          errors++;
          $display("FAIL timeout_value[%0d] got %0d required %0d", i, got[i], exp_v[i]);
        end
      end
    end
  endtask

  task automatic test_enable;
    int got[$];
    int nto;
    nto = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      checks++;
      if (o_valid !== m_valid || o_timeout !== m_timeout || o_busy !== m_busy || o_period !== m_period) begin
        errors++;
        $display("FAIL enable_model t=%0t got p=%0d v=%b to=%b b=%b required p=%0d v=%b to=%b b=%b",
                 $time, o_period, o_valid, o_timeout, o_busy, m_period, m_valid, m_timeout, m_busy);
      end
      if (k >= 4 && o_valid) got.push_back(int'(o_period));
      if (k >= 4 && o_timeout) nto++;
      if (k == 62 || k == 40) begin
        checks++;
        if (o_busy !== 1'b0) begin
          errors++;
          $display("FAIL enable_held_high got busy=%b required 0", o_busy);
        end
      end
      if (k == 68) begin
        checks++;
        if (o_busy !== 1'b1) begin
          errors++;
          $display("FAIL enable_rearm got busy=%b required 1", o_busy);
        end
      end
      i_enable = (k >= 2 && k < 19) || (k >= 34);
      i_pulse  = (k == 4) || (k == 14) || (k >= 24 && k < 60) || (k == 63) || (k == 73);
    end
    checks++;
    if (got.size() != 2 || nto != 0 || (got.size() == 2 && (got[0] != 10 || got[1] != 10))) begin
      errors++;
      $display("FAIL enable_count got %0d valids %0d timeouts required 2 valids of 10, 0 timeouts",
               got.size(), nto);
    end
  endtask

  task automatic test_reset_mid;
    int got[$];
    int first_k;
    first_k = -1;
    for (int k = 0; k < 82; k++) begin
      @(negedge clk);
      checks++;
      if (o_valid !== m_valid || o_timeout !== m_timeout || o_busy !== m_busy || o_period !== m_period) begin
        errors++;
        $display("FAIL rstmid_model t=%0t got p=%0d v=%b to=%b b=%b required p=%0d v=%b to=%b b=%b",
                 $time, o_period, o_valid, o_timeout, o_busy, m_period, m_valid, m_timeout, m_busy);
      end
      if (k == 35) begin
        checks++;
        if (o_busy !== 1'b1) begin
          errors++;
          $display("FAIL rstmid_before got busy=%b required 1", o_busy);
        end
      end
      if (k == 37) begin
        checks++;
        if (o_period !== '0 || o_busy !== 1'b0 || o_valid !== 1'b0 || o_timeout !== 1'b0) begin
          errors++;
          $display("FAIL rstmid_after got p=%0d b=%b v=%b to=%b required all zero",
                   o_period, o_busy, o_valid, o_timeout);
        end
      end
      if (k >= 37 && o_valid) begin
        got.push_back(int'(o_period));
        if (first_k < 0) first_k = k;
      end
      reset    = (k == 36);
      i_enable = (k >= 2);
      i_pulse  = (k == 4) || (k == 45) || (k == 57) || (k == 69);
    end
    checks++;
    if (got.size() != 2 || first_k <= 57 || (got.size() == 2 && (got[0] != 12 || got[1] != 12))) begin
      errors++;
      $display("FAIL rstmid_count got %0d valids first at k=%0d required 2 valids of 12 after k=57",
               got.size(), first_k);
    end
  endtask

  task automatic test_square_async;
    int got[$];
    i_pulse  = 1'b0;
    i_enable = 1'b0;
    repeat (2) @(negedge clk);
    i_enable = 1'b1;
    fork
      begin
        #3;
        repeat (12) begin
          i_pulse = 1'b1;
          #180;
          i_pulse = 1'b0;
          #190;
        end
      end
      begin
        for (int k = 0; k < 12 * 37 + 6; k++) begin
          @(negedge clk);
          checks++;
          if (o_valid !== m_valid || o_timeout !== m_timeout || o_busy !== m_busy || o_period !== m_period) begin
            errors++;
            $display("FAIL square_model t=%0t got p=%0d v=%b to=%b b=%b required p=%0d v=%b to=%b b=%b",
                     $time, o_period, o_valid, o_timeout, o_busy, m_period, m_valid, m_timeout, m_busy);
          end
          if (o_valid) begin
            got.push_back(int'(o_period));
            checks++;
            if (o_period !== CNT_W'(37) || int'(o_period) > MAXP) begin
              errors++;
              $display("FAIL square_period got %0d required 37", o_period);
            end
          end
        end
      end
    join
    checks++;
    if (got.size() != 11) begin
      errors++;
      $display("FAIL square_count got %0d valids required 11", got.size());
    end
  endtask

  task automatic test_random;
    int iv;
    int wd;
    logic en;
    for (int s = 0; s < 40; s++) begin
      iv = $urandom_range(2, MAXP + 6);
      wd = $urandom_range(1, iv - 1);
      en = ($urandom_range(0, 7) != 0);
      for (int p = 0; p < iv; p++) begin
        @(negedge clk);
        checks++;
        if (o_valid !== m_valid || o_timeout !== m_timeout || o_busy !== m_busy || o_period !== m_period) begin
          errors++;
          $display("FAIL random_model t=%0t got p=%0d v=%b to=%b b=%b required p=%0d v=%b to=%b b=%b",
                   $time, o_period, o_valid, o_timeout, o_busy, m_period, m_valid, m_timeout, m_busy);
        end
        if (o_valid && o_timeout) begin
          errors++;
          $display("FAIL random_exclusive got valid=1 timeout=1 required at most one");
        end
        i_enable = en;
        i_pulse  = (p < wd);
      end
    end
  endtask

  initial begin
    reset    = 1'b1;
    i_enable = 1'b0;
    i_pulse  = 1'b0;
    test_reset;
    test_divider_ticks;
    test_interval_seq;
    test_timeout;
    test_enable;
    test_reset_mid;
    test_square_async;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
